// File: rtl/key_pkt_pkg.sv
// Shared key-packet framing definitions, common to the transmit and receive sides.
package key_pkt_pkg;

  localparam int unsigned FRAME_LEN    = 7;
  localparam int unsigned PREAMBLE_LEN = 3;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned GAP_W        = 4;
  localparam int unsigned KEY_W        = 32;
  localparam int unsigned BYTE_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    FIN    = 3'd4
  } key_pkt_state_t;

endpackage

// File: rtl/key_packet_tx.sv
// Serialises a 32-bit key behind a 3-byte preamble, one byte per newbyt toggle.
// The frame byte port is tx_byte because "byte" is a reserved word in SystemVerilog.
module key_packet_tx
  import key_pkt_pkg::*;
#(
  parameter logic [7:0]  HDR0 = 8'hA5,
  parameter logic [7:0]  HDR1 = 8'h5A,
  parameter logic [7:0]  HDR2 = 8'h04,
  parameter int unsigned GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [31:0] key,
  input  logic        pause,
  output logic        key_ready,
  output logic [7:0]  tx_byte,
  output logic        newbyt,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP - 1);

  key_pkt_state_t      state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [KEY_W-1:0]    key_q, key_nxt;
  logic [BYTE_W-1:0]   byte_nxt, frame_byte;
  logic                newbyt_nxt, busy_nxt, done_nxt;

  assign key_ready = (state == IDLE);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
      key_q   <= '0;
      tx_byte <= '0;
      newbyt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_nxt;
      key_q   <= key_nxt;
      tx_byte <= byte_nxt;
      newbyt  <= newbyt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    gap_nxt    = gap_cnt;
    key_nxt    = key_q;
    newbyt_nxt = newbyt;
    frame_byte = 8'h00;

    case (state)
      IDLE: begin
        if (key_valid) begin
          key_nxt   = key;
          idx_nxt   = '0;
          gap_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (!pause) state_nxt = STROBE;
      end
      STROBE: begin
        newbyt_nxt = ~newbyt;
        gap_nxt    = '0;
        state_nxt  = HOLD;
      end
      HOLD: begin
        if (gap_cnt == GAP_END) begin
          gap_nxt = '0;
          if (idx == LAST_IDX) begin
            state_nxt = FIN;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = SETUP;
          end
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Byte select looks ahead so the byte is already valid during SETUP
    case (idx_nxt)
      3'd0:    frame_byte = HDR0;
      3'd1:    frame_byte = HDR1;
      3'd2:    frame_byte = HDR2;
      3'd3:    frame_byte = key_nxt[31:24];
      3'd4:    frame_byte = key_nxt[23:16];
      3'd5:    frame_byte = key_nxt[15:8];
      3'd6:    frame_byte = key_nxt[7:0];
      default: frame_byte = 8'h00;
    endcase

    byte_nxt = (state_nxt == SETUP) ? frame_byte : tx_byte;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FIN);
  end

endmodule

// File: tb/tb_key_packet_tx.sv
// Directed bench for key_packet_tx: byte scoreboard on newbyt toggles plus a loopback byte collector.
module tb_key_packet_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [31:0] key;
  logic        pause;
  logic        key_ready;
  logic [7:0]  tx_byte;
  logic        newbyt;
  logic        busy;
  logic        done;

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          tog_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  logic        prev_nb   = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [31:0] rx_buf = '0;
  logic [31:0] rx_key = '0;
  int          rx_cnt = 0;

  always #5 clk = ~clk;

  key_packet_tx #(
    .HDR0(8'hA5),
    .HDR1(8'h5A),
    .HDR2(8'h04),
    .GAP (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key      (key),
    .pause    (pause),
    .key_ready(key_ready),
    .tx_byte  (tx_byte),
    .newbyt   (newbyt),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] k);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h04);
    exp_q.push_back(k[31:24]);
    exp_q.push_back(k[23:16]);
    exp_q.push_back(k[15:8]);
    exp_q.push_back(k[7:0]);
  endtask

  // Offer a key and return just after the accepting edge
  task automatic start_frame(input logic [31:0] k);
    tick();
    key_valid = 1'b1;
    key       = k;
    chk("ready_before_accept", 32'(key_ready), 32'd1);
    push_frame(k);
    @(posedge clk);
    #1;
  endtask

  // Count cycles from accept to done; optionally hold pause and watch the held byte
  task automatic finish_frame(input int pause_at, input int pause_len, input logic [7:0] pbyte,
                              output int lat, output int t4);
    int base;
    base = tog_cnt;
    lat  = 0;
    t4   = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if (tog_cnt - base == 4 && t4 == 0) t4 = lat;
      if (pause_at != 0 && lat >= pause_at && lat <= pause_at + pause_len)
        chk("byte_held_in_pause", 32'(tx_byte), 32'(pbyte));
      if (pause_at != 0 && lat == pause_at) pause = 1'b1;
      if (pause_at != 0 && lat == pause_at + pause_len) pause = 1'b0;
      chk("ready_low_in_frame", 32'(key_ready), 32'd0);
      chk("busy_in_frame", 32'(busy), 32'd1);
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard and loopback receiver: act on every newbyt edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        rx_cnt = 0;
      end else if (newbyt !== prev_nb) begin
        tog_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_toggle", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("byte", 32'(tx_byte), 32'(mon_exp));
          chk("byte_stable", 32'(tx_byte), 32'(prev_byte));
        end
        rx_buf = {rx_buf[23:0], tx_byte};
        rx_cnt++;
        if (rx_cnt == 7) begin
          rx_key = rx_buf;
          rx_cnt = 0;
        end
      end
      prev_nb   = newbyt;
      prev_byte = tx_byte;
    end
  end

  initial begin
    int lat, t4, t0, t1;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    pause     = 1'b0;
    key       = '0;
    repeat (3) tick();
    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_newbyt", 32'(newbyt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(key_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(key_ready), 32'd1);

    // Plain frame
    t0 = tog_cnt;
    start_frame(32'hDEADBEEF);
    key_valid = 1'b0;
    finish_frame(0, 0, 8'h00, lat, t4);
    chk("latency_plain", 32'(lat), 32'd29);
    chk("t4_plain", 32'(t4), 32'd15);
    chk("toggles_plain", 32'(tog_cnt - t0), 32'd7);
    chk("newbyt_level", 32'(newbyt), 32'd1);
    chk("rx_key_plain", rx_key, 32'hDEADBEEF);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_fin", 32'(busy), 32'd0);

    // Pause held during the 4th SETUP
    t0 = tog_cnt;
    start_frame(32'hDEADBEEF);
    key_valid = 1'b0;
    finish_frame(13, 5, 8'hDE, lat, t4);
    chk("latency_pause", 32'(lat), 32'd34);
    chk("t4_pause", 32'(t4), 32'd20);
    chk("toggles_pause", 32'(tog_cnt - t0), 32'd7);
    tick();

    // Back-to-back frames with key_valid held
    t0 = tog_cnt;
    start_frame(32'h01020304);
    key = 32'hCAFEF00D;
    finish_frame(0, 0, 8'h00, lat, t4);
    chk("latency_b2b_1", 32'(lat), 32'd29);
    chk("rx_key_b2b_1", rx_key, 32'h01020304);
    tick();
    chk("ready_after_fin", 32'(key_ready), 32'd1);
    push_frame(32'hCAFEF00D);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    finish_frame(0, 0, 8'h00, lat, t4);
    chk("latency_b2b_2", 32'(lat), 32'd29);
    chk("toggles_b2b", 32'(tog_cnt - t0), 32'd14);
    chk("rx_key_b2b_2", rx_key, 32'hCAFEF00D);
    tick();

    // Key zeroed mid-frame with key_valid high; loopback must still see the original
    start_frame(32'h12345678);
    key = 32'h0;
    finish_frame(0, 0, 8'h00, lat, t4);
    key_valid = 1'b0;
    chk("latency_keychg", 32'(lat), 32'd29);
    chk("rx_key_loopback", rx_key, 32'h12345678);
    tick();
    chk("ready_fin_plus1", 32'(key_ready), 32'd1);
    tick();
    chk("no_spurious_accept", 32'(busy), 32'd0);

    // Reset after the 3rd toggle
    t0 = tog_cnt;
    start_frame(32'h11223344);
    key_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tog_cnt - t0 >= 3) break;
    end
    chk("toggles_before_reset", 32'(tog_cnt - t0), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_byte", 32'(tx_byte), 32'd0);
    chk("midrst_newbyt", 32'(newbyt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(key_ready), 32'd1);
    rst_n = 1'b1;
    t1 = tog_cnt;
    repeat (10) tick();
    chk("no_toggles_after_reset", 32'(tog_cnt - t1), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
